// File: rtl/alu_pkg.sv
// Shared op codes, FSM encoding and op decode helpers for the bit-serial ALU controller.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Signed overflow is only meaningful for the adder path (ADD/SUB).
  function automatic logic op_is_add(input logic [2:0] op);
    return op[1:0] == OP_ADD[1:0];
  endfunction

  function automatic logic op_is_slt(input logic [2:0] op);
    return op[1:0] == OP_SLT[1:0];
  endfunction

endpackage

// File: rtl/alu_serial_ctrl.sv
// Bit-serial controller: streams operands LSB-first through one external 1-bit ALU slice
// and assembles the full-width result with zero/overflow flags.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             slice_a,
  output logic             slice_bin,
  output logic             slice_cin,
  output logic             slice_less,
  output logic [2:0]       slice_op,
  input  logic             slice_result,
  input  logic             slice_cout,
  input  logic             slice_set
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             run;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] result_next;

  assign run    = (state == ST_RUN);
  assign last   = run && (idx == LAST_IDX);
  assign ready  = (state == ST_IDLE);
  assign done   = (state == ST_DONE);
  assign accept = start && ready;

  assign slice_a    = run ? a_q[idx] : 1'b0;
  assign slice_bin  = run ? b_q[idx] : 1'b0;
  assign slice_cin  = run ? carry    : 1'b0;
  assign slice_less = 1'b0;
  assign slice_op   = op_q;

  // SLT takes the MSB sum bit into bit 0 on the final cycle; no overflow correction.
  always_comb begin
    result_next      = result;
    result_next[idx] = slice_result;
    if (last && op_is_slt(op_q)) begin
      result_next[0] = slice_set;
    end
  end

  // Operand capture: data-only registers, qualified by accept rather than reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q     <= op;
            carry    <= op[2];
            idx      <= '0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          result <= result_next;
          carry  <= slice_cout;
          if (last) begin
            overflow <= op_is_add(op_q) & (carry ^ slice_cout);
            zero     <= (result_next == '0);
            state    <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
